// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command master: FSM state encoding
// and the bit positions of the pprot protection field.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  localparam int PPROT_PRIV  = 0;
  localparam int PPROT_NSEC  = 1;
  localparam int PPROT_INSTR = 2;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the APB ACCESS phase. hit pulses on the enabled cycle
// that would be the G_TIMEOUT-th stalled cycle since the last clear.
module apb_timeout_cnt #(
  parameter int G_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int CNT_W = $clog2(G_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(G_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = enable && (cnt == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// APB initiator: takes one command at a time, runs SETUP/ACCESS on m_apb_*,
// and returns the result on a response channel. Macro: APB_TIMEOUT_EN.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int G_REGWIDTH   = 32,
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [2:0]              cmd_prot,
  input  logic [G_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [G_REGWIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [G_REGWIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [2:0]              m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
  output logic [G_REGWIDTH-1:0]   m_apb_pwdata,
  input  logic                    m_apb_pready,
  input  logic [G_REGWIDTH-1:0]   m_apb_prdata,
  input  logic                    m_apb_pslverr
);

  // Both channels transfer on a rising edge where valid & ready are high;
  // the producer holds valid and its payload stable until that edge.

  apb_state_t state;
  logic       timeout_hit;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .G_TIMEOUT (G_TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == SETUP),
    .enable ((state == ACCESS) && !m_apb_pready),
    .hit    (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      rsp_timeout   <= 1'b0;
      m_apb_psel    <= 1'b0;
      m_apb_penable <= 1'b0;
      m_apb_pwrite  <= 1'b0;
      m_apb_pprot   <= '0;
      m_apb_paddr   <= '0;
      m_apb_pwdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            m_apb_pwrite <= cmd_write;
            m_apb_pprot  <= cmd_prot;
            m_apb_paddr  <= cmd_addr;
            m_apb_pwdata <= cmd_wdata;
            m_apb_psel   <= 1'b1;
            cmd_ready    <= 1'b0;
            state        <= SETUP;
          end
        end
        SETUP: begin
          m_apb_penable <= 1'b1;
          state         <= ACCESS;
        end
        ACCESS: begin
          // A completer answering on the abort cycle still wins over the timeout.
          if (m_apb_pready) begin
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= (m_apb_pwrite || m_apb_pslverr) ? '0 : m_apb_prdata;
            rsp_err       <= m_apb_pslverr;
            rsp_timeout   <= 1'b0;
            state         <= RESP;
          end else if (timeout_hit) begin
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b1;
            rsp_timeout   <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
